memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, word count of the internal array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access latency in clocks; legal range 1..15.
REQ-003 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 SHALL have port clear, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port read, input, 1, read request, held high until done.
REQ-006 SHALL have port write, input, 1, write request, held high until done.
REQ-007 SHALL have port address, input, 32, word address driven by the MAR.
REQ-008 SHALL have port wdata, input, 32, write data driven by the MDR.
REQ-009 SHALL have port rdata, output, 32, read data returned to the MDR load input.
REQ-010 SHALL have port done, output, 1, completion flag, part of a four-phase handshake.
REQ-011 SHALL have port error, output, 1, access rejected; valid only while done is high.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ACCESS, DONE; all outputs registered.
REQ-014 In IDLE, a rising edge with read or write high SHALL capture address, wdata and the request type, load the counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-015 Requests SHALL be ignored outside IDLE; captured values SHALL NOT change during ACCESS or DONE.
REQ-016 In ACCESS, the counter SHALL decrement each edge; on the edge where it is 0, the access SHALL be performed and the state SHALL enter DONE.
REQ-017 Latency: if capture occurs at edge k, done SHALL rise after edge k+WAIT_CYCLES.
REQ-018 A read SHALL load rdata with array[address] on the access edge; rdata SHALL hold until the next completed read or error.
REQ-019 A write SHALL store wdata into array[address] on the access edge; rdata SHALL be unchanged.
REQ-020 An address of DEPTH or more (any of the upper 32-log2(DEPTH) bits set) SHALL set error=1 and rdata=0, and SHALL NOT modify the array.
REQ-021 When read and write are both high at capture, the block SHALL behave as REQ-020 (error, no access).
REQ-022 In DONE, done SHALL stay high until read and write are both low; on that edge, done and error SHALL clear and the state SHALL return to IDLE.
REQ-023 A new request SHALL be accepted no earlier than the first edge after the return to IDLE; no back-to-back acceptance from DONE.
REQ-024 error SHALL be 0 whenever done is 0.

Reset
REQ-025 With clear low, the state SHALL be IDLE, the counter 0, and done=0, error=0, busy=0, rdata=0, immediately and asynchronously.
REQ-026 Reset during ACCESS SHALL abort without committing a write; reset SHALL NOT alter array contents.

Structure
REQ-027 State encoding, DEPTH default and derived ADDR_W=log2(DEPTH) SHALL reside in shared package mem_pkg.
REQ-028 Storage SHALL be one sub-module, ram_array (synchronous write, synchronous read, single port), instantiated once.

Verification
REQ-029 Write 0xDEADBEEF to address 5, then read address 5 -> read returns rdata=0xDEADBEEF, error=0, done rises exactly 2 cycles after capture.
REQ-030 Read address 0x200 (DEPTH=512) -> done=1, error=1, rdata=0; array word 0 is unchanged.
REQ-031 read and write both high at address 3 -> error=1; a subsequent read of address 3 returns its prior value.
REQ-032 Hold read high 4 cycles past done -> done stays high, busy=1; no second access; IDLE is reached one edge after read drops.
REQ-033 Pulse clear low during ACCESS of a write of 0x1234 to address 7 -> outputs are 0 at once; a later read of address 7 returns its pre-write value.
REQ-034 With WAIT_CYCLES=1 and WAIT_CYCLES=15, read address DEPTH-1 -> done rises after edge k+1 and k+15 respectively, with correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM encoding, default depth, address width.
package mem_pkg;

    localparam int unsigned DefaultDepth = 512;
    localparam int unsigned CntW         = 4;

    // Word-address width for a given array depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned AddrW = addr_w(DefaultDepth);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between the MAR/MDR side (master) and the memory responder (slave).
interface memory_responder_if;

    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        error;
    logic        busy;

    modport master (
        output read, write, address, wdata,
        input  rdata, done, error, busy
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, done, error, busy
    );

endinterface

// File: rtl/ram_array.sv
// Single-port word array: synchronous write, synchronous registered read.
module ram_array #(
    parameter int unsigned Depth = 512,
    parameter int unsigned AddrW = 9,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // One access per enabled edge; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder with a four-phase read/write handshake.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DefaultDepth,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic          clock,
    input logic          clear,
    memory_responder_if.slave bus
);

    localparam int unsigned     AW      = addr_w(DEPTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            is_write_q, is_write_d;
    logic            bad_q, bad_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            busy_q, busy_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            capture;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_rdata;

    // The array is read at the capture edge with the live address, so its output is
    // already stable when the access edge loads rdata; writes commit on the access edge.
    always_comb begin
        capture  = (state_q == StIdle) && (bus.read || bus.write);
        ram_we   = (state_q == StAccess) && (cnt_q == '0) && is_write_q && !bad_q;
        ram_en   = capture || ram_we;
        ram_addr = ram_we ? addr_q : bus.address[AW-1:0];
    end

    ram_array #(
        .Depth (DEPTH),
        .AddrW (AW),
        .Width (32)
    ) u_ram (
        .clk_i   (clock),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state for the IDLE -> ACCESS -> DONE handshake and all registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        bad_d      = bad_q;
        done_d     = done_q;
        error_d    = error_q;
        rdata_d    = rdata_q;
        case (state_q)
            StIdle: begin
                if (capture) begin
                    addr_d     = bus.address[AW-1:0];
                    wdata_d    = bus.wdata;
                    is_write_d = bus.write;
                    // Out-of-range address or a conflicting read+write is rejected.
                    bad_d      = (bus.read && bus.write) || ((bus.address >> AW) != 32'd0);
                    cnt_d      = CntLoad;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    error_d = bad_q;
                    if (bad_q) begin
                        rdata_d = 32'd0;
                    end else if (!is_write_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (!bus.read && !bus.write) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                done_d  = 1'b0;
                error_d = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; clear aborts any in-flight access.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            bad_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            bad_q      <= bad_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.done  = done_q;
    assign bus.error = error_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances (latency 2, 1 and 15) share one
// stimulus path selected by sel; expected responses go through a scoreboard queue.
module tb_memory_responder;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        read_r, write_r;
    logic [31:0] addr_r, wdata_r;
    int          sel;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    logic        done_m, error_m, busy_m;
    logic [31:0] rdata_m;

    always #5 clock = ~clock;

    memory_responder_if bus0 ();
    memory_responder_if bus1 ();
    memory_responder_if bus2 ();

    assign bus0.read    = (sel == 0) && read_r;
    assign bus0.write   = (sel == 0) && write_r;
    assign bus0.address = addr_r;
    assign bus0.wdata   = wdata_r;
    assign bus1.read    = (sel == 1) && read_r;
    assign bus1.write   = (sel == 1) && write_r;
    assign bus1.address = addr_r;
    assign bus1.wdata   = wdata_r;
    assign bus2.read    = (sel == 2) && read_r;
    assign bus2.write   = (sel == 2) && write_r;
    assign bus2.address = addr_r;
    assign bus2.wdata   = wdata_r;

    memory_responder #(.DEPTH(512), .WAIT_CYCLES(2)) dut0 (
        .clock (clock), .clear (clear), .bus (bus0)
    );
    memory_responder #(.DEPTH(512), .WAIT_CYCLES(1)) dut1 (
        .clock (clock), .clear (clear), .bus (bus1)
    );
    memory_responder #(.DEPTH(512), .WAIT_CYCLES(15)) dut2 (
        .clock (clock), .clear (clear), .bus (bus2)
    );

    always_comb begin
        done_m  = bus0.done;
        error_m = bus0.error;
        busy_m  = bus0.busy;
        rdata_m = bus0.rdata;
        if (sel == 1) begin
            done_m  = bus1.done;
            error_m = bus1.error;
            busy_m  = bus1.busy;
            rdata_m = bus1.rdata;
        end else if (sel == 2) begin
            done_m  = bus2.done;
            error_m = bus2.error;
            busy_m  = bus2.busy;
            rdata_m = bus2.rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full handshake; hold = extra cycles the request stays high after done.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic err, input logic [31:0] rexp, input logic chk_r,
                       input int hold);
        exp_t e;
        int   c;
        logic seen;
        e.lat = lat; e.err = err; e.rdata = rexp; e.chk_rdata = chk_r;
        sb.push_back(e);
        @(posedge clock); #1;
        read_r = rd; write_r = wr; addr_r = a; wdata_r = d;
        c = 0;
        seen = 1'b0;
        while (c < 40 && !seen) begin
            @(posedge clock); #1;
            c++;
            if (c == 1) chk({tag, " busy_access"}, 32'(busy_m), 32'd1);
            if (done_m) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, " timeout_done"}, 32'(done_m), 32'd1);
        end else begin
            chk({tag, " latency"}, 32'(c - 1), 32'(e.lat));
            chk({tag, " error"}, 32'(error_m), 32'(e.err));
            if (e.chk_rdata) chk({tag, " rdata"}, rdata_m, e.rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk({tag, " hold_done"}, 32'(done_m), 32'd1);
            chk({tag, " hold_busy"}, 32'(busy_m), 32'd1);
            chk({tag, " hold_rdata"}, rdata_m, e.rdata);
        end
        read_r = 1'b0; write_r = 1'b0;
        @(posedge clock); #1;
        chk({tag, " idle_done"}, 32'(done_m), 32'd0);
        chk({tag, " idle_error"}, 32'(error_m), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy_m), 32'd0);
    endtask

    initial begin
        sel = 0; read_r = 1'b0; write_r = 1'b0; addr_r = '0; wdata_r = '0;
        clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        chk("reset done", 32'(done_m), 32'd0);
        chk("reset error", 32'(error_m), 32'd0);
        chk("reset busy", 32'(busy_m), 32'd0);
        chk("reset rdata", rdata_m, 32'd0);
        @(negedge clock); clear = 1'b1;

        // Basic write then read, with the rdata-hold-over-write property.
        txn("wr5", 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 2, 1'b0, 32'd0, 1'b1, 0);
        txn("rd5", 1'b1, 1'b0, 32'd5, 32'd0, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        txn("wr0", 1'b0, 1'b1, 32'd0, 32'h1111_0000, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);

        // Out-of-range addresses.
        txn("rd200", 1'b1, 1'b0, 32'h200, 32'd0, 2, 1'b1, 32'd0, 1'b1, 0);
        txn("rd0", 1'b1, 1'b0, 32'd0, 32'd0, 2, 1'b0, 32'h1111_0000, 1'b1, 0);
        txn("wrhi", 1'b0, 1'b1, 32'h8000_0005, 32'h0, 2, 1'b1, 32'd0, 1'b1, 0);
        txn("rd5b", 1'b1, 1'b0, 32'd5, 32'd0, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);

        // Conflicting read+write is rejected and leaves the array alone.
        txn("wr3", 1'b0, 1'b1, 32'd3, 32'h3333_3333, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        txn("rdwr3", 1'b1, 1'b1, 32'd3, 32'h0BAD_0BAD, 2, 1'b1, 32'd0, 1'b1, 0);
        txn("rd3", 1'b1, 1'b0, 32'd3, 32'd0, 2, 1'b0, 32'h3333_3333, 1'b1, 0);

        // Request held past done.
        txn("rd5hold", 1'b1, 1'b0, 32'd5, 32'd0, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 4);

        // Reset in the middle of a write access.
        txn("wr7", 1'b0, 1'b1, 32'd7, 32'h7777_7777, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        txn("rd7", 1'b1, 1'b0, 32'd7, 32'd0, 2, 1'b0, 32'h7777_7777, 1'b1, 0);
        @(posedge clock); #1;
        write_r = 1'b1; addr_r = 32'd7; wdata_r = 32'h0000_1234;
        @(posedge clock); #1;
        chk("abort busy_access", 32'(busy_m), 32'd1);
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        chk("abort done", 32'(done_m), 32'd0);
        chk("abort error", 32'(error_m), 32'd0);
        chk("abort busy", 32'(busy_m), 32'd0);
        chk("abort rdata", rdata_m, 32'd0);
        write_r = 1'b0;
        @(negedge clock); clear = 1'b1;
        txn("rd7post", 1'b1, 1'b0, 32'd7, 32'd0, 2, 1'b0, 32'h7777_7777, 1'b1, 0);

        // Latency extremes at the top word.
        sel = 1;
        txn("w1 wr511", 1'b0, 1'b1, 32'd511, 32'hCAFE_0001, 1, 1'b0, 32'd0, 1'b1, 0);
        txn("w1 rd511", 1'b1, 1'b0, 32'd511, 32'd0, 1, 1'b0, 32'hCAFE_0001, 1'b1, 0);
        sel = 2;
        txn("w15 wr511", 1'b0, 1'b1, 32'd511, 32'hCAFE_000F, 15, 1'b0, 32'd0, 1'b1, 0);
        txn("w15 rd511", 1'b1, 1'b0, 32'd511, 32'd0, 15, 1'b0, 32'hCAFE_000F, 1'b1, 0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
